mem_stage: RTL

- Fourth stage of the 5-stage MIPS pipeline, between the execute stage and the write-back stage.
- Accepts the execute-stage bus and waits for the data SRAM-like response of any load issued in EX.
- Aligns and extends load data, then forwards a 124-bit bundle to WB.
- Exports bypass/stall information to decode and honours exception/eret flushes from WB.

---
 rtl/mem_stage_pkg.sv | 63 ++++++
 rtl/mem_stage_load_align.sv | 65 ++++++
 rtl/mem_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, load types,
// response-tracking states and the EX->MS / MS->WB bus payloads.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 160;
  localparam int unsigned MS_TO_WS_BUS_WD = 124;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } ld_type_e;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_HAVE = 2'd2,
    RSP_DROP = 2'd3
  } rsp_st_e;

  // EX -> MS bundle, MSB first
  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic        mem_req;
    ld_type_e    ld_type;
    logic [31:0] rt_old;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  // MS -> WB bundle, MSB first
  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment/extension and GPR byte strobe generation.
// MS_LWLR_EN: when defined, LWL/LWR merge with rt_old; otherwise they act as LW.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  ld_type_e    ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] data,
  output logic [3:0]  strb
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend or merge according to the load type
  always_comb begin
    data = rdata;
    strb = 4'b1111;
    case (ld_type)
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'd0, byte_sel};
      LD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: data = {16'd0, half_sel};
`ifdef MS_LWLR_EN
      LD_LWL: begin
        case (addr)
          2'd0:    begin data = {rdata[7:0],  rt_old[23:0]}; strb = 4'b1000; end
          2'd1:    begin data = {rdata[15:0], rt_old[15:0]}; strb = 4'b1100; end
          2'd2:    begin data = {rdata[23:0], rt_old[7:0]};  strb = 4'b1110; end
          default: begin data = rdata;                       strb = 4'b1111; end
        endcase
      end
      LD_LWR: begin
        case (addr)
          2'd1:    begin data = {rt_old[31:24], rdata[31:8]};  strb = 4'b0111; end
          2'd2:    begin data = {rt_old[31:16], rdata[31:16]}; strb = 4'b0011; end
          2'd3:    begin data = {rt_old[31:8],  rdata[31:24]}; strb = 4'b0001; end
          default: begin data = rdata;                         strb = 4'b1111; end
        endcase
      end
`endif
      default: ;
    endcase
  end

`ifndef MS_LWLR_EN
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: holds the EX bundle, tracks the data SRAM
// response of its load, aligns load data and forwards the bundle to WB.
// MS_LWLR_EN: enables LWL/LWR merging in the load aligner.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ws_allowin,
  output logic                        ms_allowin,
  input  logic                        es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
  output logic                        ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
  input  logic                        data_sram_data_ok,
  input  logic [31:0]                 data_sram_rdata,
  input  logic                        ws_ex,
  input  logic                        ws_eret,
  output logic                        ms_fwd_valid,
  output logic [4:0]                  ms_fwd_dest,
  output logic [31:0]                 ms_fwd_data,
  output logic                        ms_fwd_block,
  output logic                        ms_ex_o
);

  es_to_ms_t   es_in;
  es_to_ms_t   es_r;
  ms_to_ws_t   ws;
  logic        ms_valid;
  rsp_st_e     rsp_st;
  rsp_st_e     rsp_nxt;
  logic [31:0] rdata_buf;
  logic [31:0] rdata_sel;
  logic [31:0] al_data;
  logic [3:0]  al_strb;
  logic        flush;
  logic        ms_ready_go;
  logic        capture;
  logic        new_wait;
  logic        held_wait;

  assign es_in       = es_to_ms_t'(es_to_ms_bus);
  assign flush       = ws_ex | ws_eret;
  assign ms_ready_go = !es_r.mem_req || es_r.ex || (rsp_st == RSP_HAVE) ||
                       ((rsp_st == RSP_WAIT) && data_sram_data_ok);
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign capture     = ms_allowin && es_to_ms_valid && !flush;
  assign new_wait    = capture && es_in.mem_req && !es_in.ex;
  assign held_wait   = ms_valid && !flush && es_r.mem_req && !es_r.ex;

  // Pipeline register; a flush kills the held bundle and blocks capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      es_r     <= '0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) es_r <= es_in;
    end
  end

  // Response tracking state register
  always_ff @(posedge clk) begin
    if (reset) rsp_st <= RSP_IDLE;
    else       rsp_st <= rsp_nxt;
  end

  // Response tracking next state
  always_comb begin
    rsp_nxt = rsp_st;
    case (rsp_st)
      RSP_IDLE: if (new_wait) rsp_nxt = RSP_WAIT;
      RSP_WAIT: begin
        if (flush)                  rsp_nxt = data_sram_data_ok ? RSP_IDLE : RSP_DROP;
        else if (data_sram_data_ok) rsp_nxt = !ws_allowin ? RSP_HAVE :
                                              (new_wait ? RSP_WAIT : RSP_IDLE);
      end
      RSP_HAVE: begin
        if (flush)           rsp_nxt = RSP_IDLE;
        else if (ws_allowin) rsp_nxt = new_wait ? RSP_WAIT : RSP_IDLE;
      end
      RSP_DROP: begin
        if (data_sram_data_ok) rsp_nxt = (new_wait || held_wait) ? RSP_WAIT : RSP_IDLE;
      end
      default: rsp_nxt = RSP_IDLE;
    endcase
  end

  // Hold the load response while WB is stalled
  always_ff @(posedge clk) begin
    if (reset)                                          rdata_buf <= '0;
    else if ((rsp_st == RSP_WAIT) && data_sram_data_ok) rdata_buf <= data_sram_rdata;
  end

  assign rdata_sel = (rsp_st == RSP_HAVE) ? rdata_buf : data_sram_rdata;

  mem_stage_load_align u_align (
    .ld_type (es_r.ld_type),
    .addr    (es_r.result[1:0]),
    .rdata   (rdata_sel),
    .rt_old  (es_r.rt_old),
    .data    (al_data),
    .strb    (al_strb)
  );

  // Build the WB bundle
  always_comb begin
    ws              = '0;
    ws.excode       = es_r.excode;
    ws.badvaddr     = es_r.badvaddr;
    ws.cp0_addr     = es_r.cp0_addr;
    ws.ex           = es_r.ex;
    ws.bd           = es_r.bd;
    ws.eret         = es_r.eret;
    ws.syscall      = es_r.syscall;
    ws.mfc0         = es_r.mfc0;
    ws.mtc0         = es_r.mtc0;
    ws.dest         = es_r.dest;
    ws.pc           = es_r.pc;
    ws.gr_strb      = es_r.gr_strb;
    ws.final_result = es_r.result;
    if (es_r.ex) begin
      ws.gr_strb = 4'b0000;
    end else if (es_r.ld_type != LD_NONE) begin
      ws.gr_strb      = al_strb;
      ws.final_result = al_data;
    end
  end

  assign ms_to_ws_bus   = ws;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

  assign ms_fwd_valid = ms_valid && (|es_r.gr_strb) && !es_r.ex;
  assign ms_fwd_dest  = ms_fwd_valid ? es_r.dest : 5'd0;
  assign ms_fwd_data  = ms_fwd_valid ? ws.final_result : 32'd0;
  assign ms_fwd_block = ms_fwd_valid &&
                        (es_r.mfc0 || ((es_r.ld_type != LD_NONE) && !ms_ready_go));
  assign ms_ex_o      = ms_valid && (es_r.ex || es_r.eret);

endmodule
